// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   uts_state_e        : scheduler FSM state encoding
//   UartTxBusyTimeout  : default cycles to wait for uart_tx_busy to rise
//   UartTxNumReq       : default number of requesters
//   UartTxDataW        : default byte width
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } uts_state_e;

  localparam int unsigned UartTxBusyTimeout = 16;
  localparam int unsigned UartTxNumReq      = 4;
  localparam int unsigned UartTxDataW       = 8;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter signals of the UART transmit scheduler.
//   req_valid/req_data/req_last : per-requester byte offer (requester i at [i*DATA_W +: DATA_W])
//   req_ready                   : one-hot byte accept back to the requesters
//   uart_en/uart_din            : start pulse and byte towards the transmitter
//   uart_tx_busy                : transmitter busy flag
// master: requesters plus transmitter (environment); slave: the scheduler.
interface uart_tx_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      uart_en;
  logic [DATA_W-1:0]         uart_din;
  logic                      uart_tx_busy;

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, uart_en, uart_din
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, uart_en, uart_din
  );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: the first asserted valid bit searching upward from
// (last_i + 1) mod N with wrap-around.
//   valid_i     : request vector
//   last_i      : index of the previous winner
//   any_o       : at least one request present
//   grant_oh_o  : one-hot winner
//   grant_idx_o : winner index
module uart_tx_sched_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    valid_i,
  input  logic [IdxW-1:0] last_i,
  output logic            any_o,
  output logic [N-1:0]    grant_oh_o,
  output logic [IdxW-1:0] grant_idx_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    any_o       = 1'b0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    idx         = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IdxW'((32'(last_i) + k) % N);
      if (!any_o && valid_i[idx]) begin
        any_o           = 1'b1;
        grant_oh_o[idx] = 1'b1;
        grant_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-locked round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
// Each byte is sequenced issue -> busy rise -> busy fall; a busy flag that never rises
// ends the byte with a one-cycle err_timeout pulse.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : requester handshake and transmitter pins (slave side)
//   grant_id     : current or most recent owner
//   grant_active : a packet is in progress
//   err_timeout  : busy did not rise within BUSY_TIMEOUT cycles of uart_en
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = UartTxNumReq,
  parameter int unsigned DATA_W       = UartTxDataW,
  parameter int unsigned BUSY_TIMEOUT = UartTxBusyTimeout,
  localparam int unsigned IdxW        = $clog2(NUM_REQ),
  localparam int unsigned CntW        = $clog2(BUSY_TIMEOUT)
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_sched_if.slave  bus,
  output logic [IdxW-1:0] grant_id,
  output logic            grant_active,
  output logic            err_timeout
);

  uts_state_e          state_q, state_d;
  logic [IdxW-1:0]     grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]  grant_oh_q, grant_oh_d;
  logic                grant_active_q, grant_active_d;
  logic [IdxW-1:0]     last_ptr_q, last_ptr_d;
  logic                pkt_last_q, pkt_last_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                uart_en_q, uart_en_d;
  logic [DATA_W-1:0]   uart_din_q, uart_din_d;
  logic                err_q, err_d;

  logic                arb_any;
  logic [NUM_REQ-1:0]  arb_oh;
  logic [IdxW-1:0]     arb_idx;
  logic [NUM_REQ-1:0]  ready;
  logic                sel_valid, sel_last, byte_done;
  logic [DATA_W-1:0]   sel_data;

  uart_tx_sched_rr_arbiter #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_arb (
    .valid_i     (bus.req_valid),
    .last_i      (last_ptr_q),
    .any_o       (arb_any),
    .grant_oh_o  (arb_oh),
    .grant_idx_o (arb_idx)
  );

  assign sel_valid = |(bus.req_valid & grant_oh_q);
  assign sel_last  = |(bus.req_last & grant_oh_q);
  assign sel_data  = bus.req_data[32'(grant_id_q) * DATA_W +: DATA_W];

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    grant_oh_d     = grant_oh_q;
    grant_active_d = grant_active_q;
    last_ptr_d     = last_ptr_q;
    pkt_last_d     = pkt_last_q;
    cnt_d          = cnt_q;
    uart_din_d     = uart_din_q;
    uart_en_d      = 1'b0;
    err_d          = 1'b0;
    ready          = '0;
    byte_done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          grant_id_d     = arb_idx;
          grant_oh_d     = arb_oh;
          grant_active_d = 1'b1;
          state_d        = StIssue;
        end
      end
      StIssue: begin
        // A transmitter still draining (or driven by someone else) holds off the accept.
        if (!bus.uart_tx_busy) begin
          ready = grant_oh_q;
          if (sel_valid) begin
            uart_en_d  = 1'b1;
            uart_din_d = sel_data;
            pkt_last_d = sel_last;
            cnt_d      = '0;
            state_d    = StWaitBusy;
          end
        end
      end
      StWaitBusy: begin
        if (bus.uart_tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
          err_d     = 1'b1;
          byte_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!bus.uart_tx_busy) byte_done = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // The lock is only released by a byte flagged last.
    if (byte_done) begin
      if (pkt_last_q) begin
        last_ptr_d     = grant_id_q;
        grant_active_d = 1'b0;
        state_d        = StIdle;
      end else begin
        state_d = StIssue;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      grant_id_q     <= '0;
      grant_oh_q     <= '0;
      grant_active_q <= 1'b0;
      last_ptr_q     <= IdxW'(NUM_REQ - 1);
      pkt_last_q     <= 1'b0;
      cnt_q          <= '0;
      uart_en_q      <= 1'b0;
      uart_din_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      grant_oh_q     <= grant_oh_d;
      grant_active_q <= grant_active_d;
      last_ptr_q     <= last_ptr_d;
      pkt_last_q     <= pkt_last_d;
      cnt_q          <= cnt_d;
      uart_en_q      <= uart_en_d;
      uart_din_q     <= uart_din_d;
      err_q          <= err_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.uart_en   = uart_en_q;
  assign bus.uart_din  = uart_din_q;
  assign grant_id      = grant_id_q;
  assign grant_active  = grant_active_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed packets are queued per requester and the
// expected line order is pushed to a queue; a monitor pops on every uart_en.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int unsigned NReq    = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned Tmo     = 16;
  localparam int          BusyLen = 10;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant_id;
  logic       grant_active;
  logic       err_timeout;

  uart_tx_sched_if #(.NUM_REQ(NReq), .DATA_W(DW)) uif ();

  uart_tx_sched #(
    .NUM_REQ      (NReq),
    .DATA_W       (DW),
    .BUSY_TIMEOUT (Tmo)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (uif),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   last_en_cyc = 0;
  int   en_seen = 0;
  int   err_cnt = 0;
  int   rdy0_cnt = 0;
  int   bad_ready = 0;
  bit   tx_mute = 1'b0;
  exp_t exp_q[$];
  logic [8:0] src_q [NReq][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_byte(input int id, input int data);
    exp_t e;
    e.id   = 2'(id);
    e.data = 8'(data);
    exp_q.push_back(e);
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < NReq; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Requesters: present the head of each queue, pop it once accepted.
  initial begin : drv
    logic [NReq-1:0] acc;
    uif.req_valid = '0;
    uif.req_data  = '0;
    uif.req_last  = '0;
    forever begin
      @(negedge clk);
      acc = uif.req_valid & uif.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NReq; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          uif.req_valid[i]         = 1'b1;
          uif.req_data[i*DW +: DW] = src_q[i][0][7:0];
          uif.req_last[i]          = src_q[i][0][8];
        end else begin
          uif.req_valid[i] = 1'b0;
          uif.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Transmitter model: busy rises the cycle after uart_en and stays high BusyLen cycles.
  initial begin : txm
    int busy_left;
    bit pend;
    busy_left = 0;
    pend = 1'b0;
    uif.uart_tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_left > 0) busy_left--;
      if (pend) begin
        pend = 1'b0;
        busy_left = BusyLen;
      end
      if (uif.uart_en && !tx_mute) pend = 1'b1;
      uif.uart_tx_busy = (busy_left > 0);
    end
  end

  // Monitor / scoreboard.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!$onehot0(uif.req_ready)) bad_ready++;
        if (uif.req_ready[0]) rdy0_cnt++;
        if (uif.uart_en) begin
          if (en_seen > 0) check("en_spacing_ge3", int'(cyc - last_en_cyc >= 3), 1);
          last_en_cyc = cyc;
          en_seen++;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_en: got din 0x%0h grant %0d, expected no pulse",
                     uif.uart_din, grant_id);
          end else begin
            e = exp_q.pop_front();
            check("line_data", int'(uif.uart_din), int'(e.data));
            check("line_grant", int'(grant_id), int'(e.id));
          end
        end
        if (err_timeout) begin
          err_cnt++;
          if (tx_mute) begin
            check("err_delay", cyc - last_en_cyc, Tmo);
          end else begin
            n_total++;
            $display("FAIL unexpected_err: got err_timeout=1, expected 0");
          end
        end
      end
    end
  end

  task automatic wait_en(output int t);
    t = -1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (uif.uart_en) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_total++;
      $display("FAIL wait_en: got no uart_en in 500 cycles, expected a pulse");
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!grant_active && !uif.uart_tx_busy && src_empty()) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL wait_idle: got busy scheduler after 3000 cycles, expected idle");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_uart_en"}, int'(uif.uart_en), 0);
    check({tag, "_uart_din"}, int'(uif.uart_din), 0);
    check({tag, "_req_ready"}, int'(uif.req_ready), 0);
    check({tag, "_grant_id"}, int'(grant_id), 0);
    check({tag, "_grant_active"}, int'(grant_active), 0);
    check({tag, "_err_timeout"}, int'(err_timeout), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion by 500us, expected summary");
    $fatal(1);
  end

  initial begin : main
    int t_v, t_e, base, gap_en;
    bit seen;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte from requester 0.
    base = rdy0_cnt;
    src_q[0].push_back({1'b1, 8'h55});
    expect_byte(0, 8'h55);
    t_v = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (uif.req_valid[0]) begin
        t_v = cyc;
        break;
      end
    end
    wait_en(t_e);
    check("t1_en_latency", t_e - t_v, 2);
    wait_idle();
    check("t1_grant_active", int'(grant_active), 0);
    check("t1_ready0_cycles", rdy0_cnt - base, 1);

    // Two 3-byte packets competing: no interleaving, then rotation continues at 3.
    apply_reset();
    src_q[1].push_back({1'b0, 8'hA0});
    src_q[1].push_back({1'b0, 8'hA1});
    src_q[1].push_back({1'b1, 8'hA2});
    src_q[2].push_back({1'b0, 8'hB0});
    src_q[2].push_back({1'b0, 8'hB1});
    src_q[2].push_back({1'b1, 8'hB2});
    expect_byte(1, 8'hA0);
    expect_byte(1, 8'hA1);
    expect_byte(1, 8'hA2);
    expect_byte(2, 8'hB0);
    expect_byte(2, 8'hB1);
    expect_byte(2, 8'hB2);
    wait_idle();
    check("t2_last_owner", int'(grant_id), 2);
    src_q[0].push_back({1'b1, 8'h30});
    src_q[3].push_back({1'b1, 8'h33});
    expect_byte(3, 8'h33);
    expect_byte(0, 8'h30);
    wait_idle();

    // All four continuously valid with 1-byte packets: strict rotation.
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      src_q[r].push_back({1'b1, 8'(8'h40 + r)});
      src_q[r].push_back({1'b1, 8'(8'h50 + r)});
    end
    for (int r = 0; r < 4; r++) expect_byte(r, 8'h40 + r);
    for (int r = 0; r < 4; r++) expect_byte(r, 8'h50 + r);
    wait_idle();

    // Requester 0 goes quiet mid-packet while requester 3 waits.
    src_q[0].push_back({1'b0, 8'hC0});
    src_q[3].push_back({1'b1, 8'hD3});
    expect_byte(0, 8'hC0);
    wait_en(t_e);
    gap_en = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (uif.uart_en) gap_en++;
    end
    check("t4_gap_en_count", gap_en, 0);
    check("t4_lock_owner", int'(grant_id), 0);
    check("t4_lock_active", int'(grant_active), 1);
    src_q[0].push_back({1'b1, 8'hC1});
    expect_byte(0, 8'hC1);
    expect_byte(3, 8'hD3);
    wait_idle();

    // Busy never rises: each byte times out and the packet still completes.
    tx_mute = 1'b1;
    base = err_cnt;
    src_q[1].push_back({1'b0, 8'hE0});
    src_q[1].push_back({1'b1, 8'hE1});
    expect_byte(1, 8'hE0);
    expect_byte(1, 8'hE1);
    wait_idle();
    check("t5_err_pulses", err_cnt - base, 2);
    check("t5_released", int'(grant_active), 0);
    tx_mute = 1'b0;

    // Asynchronous reset while waiting for the byte to drain.
    src_q[2].push_back({1'b0, 8'hF0});
    src_q[2].push_back({1'b1, 8'hF1});
    expect_byte(2, 8'hF0);
    wait_en(t_e);
    repeat (3) @(negedge clk);
    seen = uif.uart_tx_busy;
    check("t6_busy_before_reset", int'(seen), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6");
    src_q[2].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    src_q[0].push_back({1'b1, 8'h60});
    src_q[3].push_back({1'b1, 8'h63});
    expect_byte(0, 8'h60);
    expect_byte(3, 8'h63);
    wait_idle();

    check("sb_empty", exp_q.size(), 0);
    check("ready_onehot_violations", bad_ready, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_send transmitter between NUM_REQ byte requesters (CPU bus port, debug monitor, DMA, …).
- Sits between the requesters and the transmitter's uart_en / uart_din / uart_tx_busy pins.
- Packet-locked: once a requester is granted, it keeps the transmitter until it sends a byte flagged last.
- Sequences each byte as issue, busy-rise, busy-fall, and recovers with an error pulse if busy never rises.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- BUSY_TIMEOUT, 16, max cycles to wait for uart_tx_busy to rise after uart_en (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  byte is last of packet; releases the lock.
- req_ready  out  NUM_REQ  one-hot byte accept.
- uart_en  out  1  one-cycle start pulse to transmitter.
- uart_din  out  DATA_W  byte to transmitter.
- uart_tx_busy  in  1  transmitter busy.
- grant_id  out  $clog2(NUM_REQ)  current or last owner.
- grant_active  out  1  a packet is in progress.
- err_timeout  out  1  one-cycle pulse when busy failed to rise.

Behaviour:
- Reset values: state IDLE, uart_en=0, uart_din=0, req_ready=0, grant_id=0, grant_active=0, err_timeout=0, rr pointer last=NUM_REQ-1 (requester 0 has first priority), timeout counter 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid: pick the first valid index searching from (last+1) mod NUM_REQ upward with wrap.
  - Register the pick into grant_id, set grant_active=1, go to ISSUE.
  - Arbitration costs 1 cycle.
- ISSUE:
  - req_ready[grant_id] = (state==ISSUE) && !uart_tx_busy. This is combinational; all other ready bits are 0.
  - Transfer occurs when req_valid[grant_id] && req_ready[grant_id].
  - On transfer, at the next edge: uart_en=1 for exactly one cycle, uart_din=req_data of the grant (held until the next transfer), last_q captured, counter cleared, go to WAIT_BUSY.
  - If the granted valid is low, stay in ISSUE. The lock holds; other requesters are ignored.
- WAIT_BUSY:
  - busy=1 → WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1, pulse err_timeout for one cycle and treat the byte as complete (same exit as WAIT_DONE).
- WAIT_DONE, on busy=0:
  - If last_q: last=grant_id, grant_active=0, go to IDLE.
  - Otherwise go to ISSUE with the same grant.
- uart_en is never high on two consecutive cycles. There are always at least 3 cycles between pulses.
- Busy already high in ISSUE (transmitter owned elsewhere or still draining): ready stays low until it drops.
- Simultaneous valid from all requesters: strict rotation by packet, never by byte.
- A requester dropping valid mid-packet does not release the lock; only a last byte or reset does.
- Reset mid-byte: all state clears immediately (async). A partially sent byte on the line is the transmitter's concern; no uart_en is emitted until after a new arbitration.
- grant_id holds its value after release (informational).

Decomposition:
- Shared package/include (para.v):
  - state encodings UTS_IDLE=2'd0, UTS_ISSUE=2'd1, UTS_WAIT_BUSY=2'd2, UTS_WAIT_DONE=2'd3.
  - default UART_TX_BUSY_TIMEOUT.
- One natural sub-module: rr_arbiter, a combinational round-robin pick from valid vector + last pointer, producing one-hot grant and index. It is reusable for other shared peripherals.

Test Plan:
- Single requester 0 sends 0x55 with last=1; model busy high 10 cycles after uart_en.
  - Exactly one uart_en pulse with uart_din=0x55, 2 cycles after valid.
  - ready[0] high exactly one cycle.
  - Returns to IDLE, grant_active=0.
- Requesters 1 and 2 both valid from reset, each with a 3-byte packet (A0,A1,A2 / B0,B1,B2).
  - Line order is A0,A1,A2,B0,B1,B2 with no interleaving.
  - The next arbitration starts at 3.
- All four requesters continuously valid with 1-byte packets.
  - Grants go 0,1,2,3,0 and are fair.
- Requester 0 drops valid between byte 1 and byte 2 for 20 cycles while requester 3 is valid.
  - No uart_en during the gap; requester 3 is not granted until after requester 0's last byte.
- uart_tx_busy never rises after uart_en with BUSY_TIMEOUT=16.
  - err_timeout pulses exactly 16 cycles after uart_en.
  - The scheduler proceeds to the next byte.
- Assert rst_n low while in WAIT_DONE.
  - All outputs go to reset values asynchronously.
  - After release, requester 0 wins arbitration first.
